// File: rtl/bram_port_arb.sv
// Two-requester arbiter for BRAM port 0: round-robin with optional burst lock,
// routing the one-cycle-latency read data back to the requester that issued the read.
module bram_port_arb #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            m0_req,
  input  logic            m0_lock,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW/8-1:0] m0_wen,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_lock,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW/8-1:0] m1_wen,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic [AW-1:0]   b_addr,
  output logic [DW/8-1:0] b_wen,
  output logic            b_rden,
  output logic [DW-1:0]   b_wdata,
  input  logic [DW-1:0]   b_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   m0_rvalid_q, m1_rvalid_q;

  // last_q names the requester granted most recently; the other one wins a tie.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    case (state_q)
      OWN0:    m0_gnt = m0_req;
      OWN1:    m1_gnt = m1_req;
      default: begin
        m0_gnt = m0_req && (!m1_req || last_q);
        m1_gnt = m1_req && !m0_gnt;
      end
    endcase
    if (!resetn) begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
    end
  end

  always_comb begin
    b_addr  = '0;
    b_wen   = '0;
    b_wdata = '0;
    b_rden  = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    if (m0_gnt) begin
      b_addr  = m0_addr;
      b_wen   = m0_wen;
      b_wdata = m0_wdata;
      b_rden  = (m0_wen == '0);
      state_d = m0_lock ? OWN0 : IDLE;
      last_d  = 1'b0;
    end else if (m1_gnt) begin
      b_addr  = m1_addr;
      b_wen   = m1_wen;
      b_wdata = m1_wdata;
      b_rden  = (m1_wen == '0);
      state_d = m1_lock ? OWN1 : IDLE;
      last_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      m0_rvalid_q <= m0_gnt && (m0_wen == '0);
      m1_rvalid_q <= m1_gnt && (m1_wen == '0);
    end
  end

  // Port 0 of the wrapper is write-first, so read data needs no bypass here.
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = b_rdata;
  assign m1_rdata  = b_rdata;

endmodule

// File: tb/tb_bram_port_arb.sv
// Bench for bram_port_arb: BRAM behavioural model, per-cycle reference model of
// the arbitration rules with a shadow memory, directed scenarios plus random traffic.
module tb_bram_port_arb;
  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_req, m0_lock, m1_req, m1_lock;
  logic [9:0]  m0_addr, m1_addr, b_addr;
  logic [3:0]  m0_wen, m1_wen, b_wen;
  logic [31:0] m0_wdata, m1_wdata, b_wdata, b_rdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, b_rden;
  logic [31:0] m0_rdata, m1_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bram_port_arb #(.AW(10), .DW(32)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wen(m0_wen),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wen(m1_wen),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .b_addr(b_addr), .b_wen(b_wen), .b_rden(b_rden), .b_wdata(b_wdata), .b_rdata(b_rdata)
  );

  // BRAM port 0 stand-in, driven only by the DUT
  logic [31:0] mem [1024];
  initial b_rdata = '0;
  always @(posedge clk) begin
    if (b_rden) b_rdata <= mem[b_addr];
    for (int k = 0; k < 4; k++)
      if (b_wen[k]) mem[b_addr][8*k +: 8] <= b_wdata[8*k +: 8];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] sh [1024];
  int          own  = -1;   // -1: nobody holds the lock
  int          last = 1;
  bit          erv [2] = '{1'b0, 1'b0};
  logic [31:0] edat [2];

  function automatic bit rq(int i); return i ? m1_req : m0_req; endfunction
  function automatic bit lk(int i); return i ? m1_lock : m0_lock; endfunction
  function automatic logic [9:0] ad(int i); return i ? m1_addr : m0_addr; endfunction
  function automatic logic [3:0] wn(int i); return i ? m1_wen : m0_wen; endfunction
  function automatic logic [31:0] wd(int i); return i ? m1_wdata : m0_wdata; endfunction

  function automatic int winner();
    if (own >= 0) return rq(own) ? own : -1;
    if (rq(0) && rq(1)) return 1 - last;
    if (rq(0)) return 0;
    if (rq(1)) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin : model_upd
    int w;
    if (!resetn) begin
      own <= -1; last <= 1; erv[0] <= 1'b0; erv[1] <= 1'b0;
    end else begin
      w = winner();
      erv[0] <= 1'b0; erv[1] <= 1'b0;
      if (w >= 0) begin
        last <= w;
        own  <= lk(w) ? w : -1;
        if (wn(w) == 4'd0) begin
          erv[w]  <= 1'b1;
          edat[w] <= sh[ad(w)];
        end else begin
          for (int k = 0; k < 4; k++)
            if (wn(w)[k]) sh[ad(w)][8*k +: 8] <= wd(w)[8*k +: 8];
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int w;
    if (!resetn) begin
      chk("gnt0_rst", {31'd0, m0_gnt}, 32'd0);
      chk("gnt1_rst", {31'd0, m1_gnt}, 32'd0);
      chk("rden_rst", {31'd0, b_rden}, 32'd0);
      chk("wen_rst",  {28'd0, b_wen},  32'd0);
    end else begin
      w = winner();
      chk("gnt0", {31'd0, m0_gnt}, {31'd0, w == 0});
      chk("gnt1", {31'd0, m1_gnt}, {31'd0, w == 1});
      if (w >= 0) begin
        chk("b_addr",  {22'd0, b_addr}, {22'd0, ad(w)});
        chk("b_wen",   {28'd0, b_wen},  {28'd0, wn(w)});
        chk("b_rden",  {31'd0, b_rden}, {31'd0, wn(w) == 4'd0});
        if (wn(w) != 4'd0) chk("b_wdata", b_wdata, wd(w));
      end else begin
        chk("rden_idle", {31'd0, b_rden}, 32'd0);
        chk("wen_idle",  {28'd0, b_wen},  32'd0);
      end
    end
    chk("rvalid0", {31'd0, m0_rvalid}, {31'd0, erv[0]});
    chk("rvalid1", {31'd0, m1_rvalid}, {31'd0, erv[1]});
    if (erv[0]) chk("rdata0", m0_rdata, edat[0]);
    if (erv[1]) chk("rdata1", m1_rdata, edat[1]);
  end

  // ---------------- stimulus ----------------
  task automatic step(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); endtask

  task automatic set0(input bit r, input bit l, input logic [9:0] a, input logic [3:0] we, input logic [31:0] d);
    m0_req = r; m0_lock = l; m0_addr = a; m0_wen = we; m0_wdata = d;
  endtask
  task automatic set1(input bit r, input bit l, input logic [9:0] a, input logic [3:0] we, input logic [31:0] d);
    m1_req = r; m1_lock = l; m1_addr = a; m1_wen = we; m1_wdata = d;
  endtask

  task automatic rnd(input int who);
    bit r, l; logic [9:0] a; logic [3:0] we;
    r  = ($urandom_range(0, 3) != 0);
    l  = ($urandom_range(0, 3) == 0);
    a  = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
    we = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
    if (who == 0) set0(r, l, a, we, $urandom);
    else          set1(r, l, a, we, $urandom);
  endtask

  initial begin
    bit h0, h1;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'hC0DE_0000 ^ (i * 32'h0001_0003);
      sh[i]  = 32'hC0DE_0000 ^ (i * 32'h0001_0003);
    end
    mem[10'h3FF] = 32'h1122_3344;
    sh[10'h3FF]  = 32'h1122_3344;

    // reset with both requesting, then round-robin alternation
    resetn = 1'b0;
    set0(1, 0, 10'h000, 4'h0, 32'h0);
    set1(1, 0, 10'h001, 4'h0, 32'h0);
    repeat (2) begin
      mid();
      chk("L_rst_gnt0", {31'd0, m0_gnt}, 32'd0);
      chk("L_rst_gnt1", {31'd0, m1_gnt}, 32'd0);
      chk("L_rst_rden", {31'd0, b_rden}, 32'd0);
      step();
    end
    resetn = 1'b1;
    mid(); chk("L_first_gnt0", {31'd0, m0_gnt}, 32'd1); step();
    mid(); chk("L_second_gnt1", {31'd0, m1_gnt}, 32'd1); step();

    // write then single read by m0
    set1(0, 0, 10'h0, 4'h0, 32'h0);
    set0(1, 0, 10'h005, 4'hF, 32'hDEADBEEF);
    mid(); chk("L_wr_gnt0", {31'd0, m0_gnt}, 32'd1); step();
    set0(1, 0, 10'h005, 4'h0, 32'h0);
    mid();
    chk("L_rd_rden", {31'd0, b_rden}, 32'd1);
    chk("L_rd_addr", {22'd0, b_addr}, 32'h005);
    step();
    set0(0, 0, 10'h0, 4'h0, 32'h0);
    mid();
    chk("L_rd_rvalid0", {31'd0, m0_rvalid}, 32'd1);
    chk("L_rd_rdata0", m0_rdata, 32'hDEADBEEF);
    chk("L_rd_rvalid1", {31'd0, m1_rvalid}, 32'd0);
    step();

    // byte write by m1, read-back merges into old word
    set1(1, 0, 10'h3FF, 4'b0100, 32'h00AB0000);
    mid(); chk("L_bw_gnt1", {31'd0, m1_gnt}, 32'd1); step();
    set1(1, 0, 10'h3FF, 4'h0, 32'h0);
    step();
    set1(0, 0, 10'h0, 4'h0, 32'h0);
    mid();
    chk("L_bw_rvalid1", {31'd0, m1_rvalid}, 32'd1);
    chk("L_bw_rdata1", m1_rdata, 32'h11AB3344);
    step();

    // locked burst by m1 while m0 keeps requesting
    set0(1, 0, 10'h000, 4'h0, 32'h0);
    step();
    set0(1, 0, 10'h001, 4'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      set1(1, k < 3, 10'h100 + 10'(k), 4'h0, 32'h0);
      mid();
      chk("L_burst_gnt1", {31'd0, m1_gnt}, 32'd1);
      chk("L_burst_gnt0", {31'd0, m0_gnt}, 32'd0);
      if (k > 0) chk("L_burst_rvalid1", {31'd0, m1_rvalid}, 32'd1);
      step();
    end
    set1(0, 0, 10'h0, 4'h0, 32'h0);
    mid();
    chk("L_after_burst_gnt0", {31'd0, m0_gnt}, 32'd1);
    chk("L_burst_last_rvalid1", {31'd0, m1_rvalid}, 32'd1);
    step();

    // lock held by m0 across a request gap
    set0(1, 1, 10'h002, 4'h0, 32'h0);
    mid(); chk("L_gap_lockbeat", {31'd0, m0_gnt}, 32'd1); step();
    set0(0, 0, 10'h0, 4'h0, 32'h0);
    set1(1, 0, 10'h003, 4'h0, 32'h0);
    repeat (3) begin
      mid(); chk("L_gap_gnt1_held", {31'd0, m1_gnt}, 32'd0); step();
    end
    set0(1, 0, 10'h004, 4'h0, 32'h0);
    mid(); chk("L_gap_release_gnt0", {31'd0, m0_gnt}, 32'd1); step();
    set0(0, 0, 10'h0, 4'h0, 32'h0);
    mid(); chk("L_gap_then_gnt1", {31'd0, m1_gnt}, 32'd1); step();

    // reset while m1 owns the port with a read in flight
    set1(1, 1, 10'h004, 4'h0, 32'h0);
    step();
    set1(1, 1, 10'h005, 4'h0, 32'h0);
    mid();
    chk("L_own1_gnt1", {31'd0, m1_gnt}, 32'd1);
    #1 resetn = 1'b0;
    step();
    mid(); chk("L_rst_drop_rvalid1", {31'd0, m1_rvalid}, 32'd0);
    step();
    resetn = 1'b1;
    set0(1, 0, 10'h006, 4'h0, 32'h0);
    set1(1, 0, 10'h007, 4'h0, 32'h0);
    mid(); chk("L_post_rst_gnt0", {31'd0, m0_gnt}, 32'd1); step();

    // random traffic honouring the hold-while-waiting rule
    h0 = 1'b0; h1 = 1'b0;
    repeat (3000) begin
      mid();
      h0 = resetn && m0_req && !m0_gnt;
      h1 = resetn && m1_req && !m1_gnt;
      step();
      resetn = ($urandom_range(0, 99) != 0);
      if (!h0) rnd(0);
      if (!h1) rnd(1);
    end
    resetn = 1'b1;
    set0(0, 0, 10'h0, 4'h0, 32'h0);
    set1(0, 0, 10'h0, 4'h0, 32'h0);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
